// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN / ILEN      : address and instruction widths
//   IFQ_DEPTH        : depth of the fetch queue
//   ifq_entry_t      : one queued instruction {pc, instr, fault}
//   FAULT_* / PUSH_* : fault flag encoding and push-count encodings
package ifetch_unit_pkg;

   localparam int XLEN      = 64;
   localparam int ILEN      = 32;
   localparam int IFQ_DEPTH = 4;
   localparam int IFQ_CNT_W = 3;   // holds 0..IFQ_DEPTH

   localparam logic FAULT_NONE  = 1'b0;
   localparam logic FAULT_FETCH = 1'b1;

   localparam logic [1:0] PUSH_NONE = 2'd0;
   localparam logic [1:0] PUSH_ONE  = 2'd1;
   localparam logic [1:0] PUSH_TWO  = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            fault;
   } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Four-entry instruction FIFO with a two-wide push port and one-wide pop port.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_flush           : empties the queue; pushes and pops that cycle are dropped
//   i_push_cnt        : number of entries to push this cycle (0..2)
//   i_push0, i_push1  : entries to push, i_push0 first
//   i_pop             : remove the head entry (ignored when empty)
//   o_valid, o_head   : head entry and its valid flag
//   o_count           : number of occupied entries (0..4)
// Handshake: an entry leaves when o_valid and i_pop are both high at a rising
// edge; the caller never pushes more entries than there are free slots.
module ifetch_queue
   import ifetch_unit_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic [1:0]           i_push_cnt,
   input  ifq_entry_t           i_push0,
   input  ifq_entry_t           i_push1,
   input  logic                 i_pop,
   output logic                 o_valid,
   output ifq_entry_t           o_head,
   output logic [IFQ_CNT_W-1:0] o_count
);

   ifq_entry_t           r_mem [IFQ_DEPTH];
   logic [1:0]           r_rd_ptr;
   logic [1:0]           r_wr_ptr;
   logic [IFQ_CNT_W-1:0] r_count;
   logic                 w_pop;
   logic                 w_write;

   assign w_pop   = i_pop && (r_count != '0);
   assign w_write = !i_rst && !i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + i_push_cnt;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         r_count <= r_count + {1'b0, i_push_cnt} - {2'b00, w_pop};
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_write && (i_push_cnt != PUSH_NONE)) begin
         r_mem[r_wr_ptr] <= i_push0;
      end
      if (w_write && (i_push_cnt == PUSH_TWO)) begin
         r_mem[r_wr_ptr + 2'd1] <= i_push1;
      end
   end

   assign o_valid = (r_count != '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage in front of the instruction ROM.
// Owns the fetch PC, addresses the ROM one 64-bit line at a time, splits each
// line into 32-bit instructions and queues them for decode.
//   HCLK, HRESET          : clock, synchronous active-high reset
//   HADDR, HWDATA, HRDATA : ROM line address (8-byte aligned), write data (0),
//                           combinational read data for HADDR (little-endian)
//   redirect_valid/_pc    : load a new fetch PC and flush the queue
//   if_valid/if_ready     : decode handshake; the head moves when both are high
//   if_pc/if_instr/if_fault : head entry, zeroed while if_valid is low
//   o_dbg_count/_halted   : queue occupancy and halted flag for observation
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
   parameter logic [XLEN-1:0] ROM_START = 64'h0,
   parameter int unsigned     ROM_SIZE  = 256
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   output logic [XLEN-1:0]      HADDR,
   output logic [XLEN-1:0]      HWDATA,
   input  logic [XLEN-1:0]      HRDATA,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   output logic                 if_valid,
   input  logic                 if_ready,
   output logic [XLEN-1:0]      if_pc,
   output logic [ILEN-1:0]      if_instr,
   output logic                 if_fault,
   output logic [IFQ_CNT_W-1:0] o_dbg_count,
   output logic                 o_dbg_halted
);

   localparam logic [XLEN-1:0] LINE_LIMIT = XLEN'(ROM_SIZE) - XLEN'(8);

   logic [XLEN-1:0]      r_fetch_pc;
   logic                 r_halted;

   logic [XLEN-1:0]      w_line;
   logic                 w_legal;
   logic                 w_fetch;
   logic [1:0]           w_push_cnt;
   ifq_entry_t           w_push0;
   ifq_entry_t           w_push1;
   logic [XLEN-1:0]      w_next_pc;
   logic                 w_set_halt;
   logic                 w_q_valid;
   ifq_entry_t           w_q_head;
   logic [IFQ_CNT_W-1:0] w_q_count;

   assign w_line = {r_fetch_pc[XLEN-1:3], 3'b000};
   // Lower bound first so the offset subtraction cannot wrap.
   assign w_legal = (w_line >= ROM_START) && ((w_line - ROM_START) < LINE_LIMIT);
   // Registered count only: a pop in this cycle does not open room for a fetch.
   assign w_fetch = !r_halted && (w_q_count <= 3'd2) && !redirect_valid;

   always_comb begin
      w_push_cnt = PUSH_NONE;
      w_push0    = '0;
      w_push1    = '0;
      w_next_pc  = r_fetch_pc;
      w_set_halt = 1'b0;
      if (w_fetch) begin
         if (w_legal && (r_fetch_pc[1:0] == 2'b00)) begin
            if (!r_fetch_pc[2]) begin
               w_push_cnt = PUSH_TWO;
               w_push0    = '{pc: r_fetch_pc, instr: HRDATA[31:0], fault: FAULT_NONE};
               w_push1    = '{pc: r_fetch_pc + 64'd4, instr: HRDATA[63:32], fault: FAULT_NONE};
               w_next_pc  = r_fetch_pc + 64'd8;
            end else begin
               w_push_cnt = PUSH_ONE;
               w_push0    = '{pc: r_fetch_pc, instr: HRDATA[63:32], fault: FAULT_NONE};
               w_next_pc  = r_fetch_pc + 64'd4;
            end
         end else begin
            // Emit one fault marker, then stop until redirected or reset.
            w_push_cnt = PUSH_ONE;
            w_push0    = '{pc: r_fetch_pc, instr: '0, fault: FAULT_FETCH};
            w_set_halt = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_fetch_pc <= RESET_PC;
         r_halted   <= 1'b0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         r_halted   <= 1'b0;
      end else begin
         r_fetch_pc <= w_next_pc;
         if (w_set_halt) begin
            r_halted <= 1'b1;
         end
      end
   end

   ifetch_queue u_queue (
      .i_clk      (HCLK),
      .i_rst      (HRESET),
      .i_flush    (redirect_valid),
      .i_push_cnt (w_push_cnt),
      .i_push0    (w_push0),
      .i_push1    (w_push1),
      .i_pop      (if_ready),
      .o_valid    (w_q_valid),
      .o_head     (w_q_head),
      .o_count    (w_q_count)
   );

   assign HADDR        = w_line;
   assign HWDATA       = '0;
   assign if_valid     = w_q_valid;
   assign if_pc        = w_q_valid ? w_q_head.pc    : '0;
   assign if_instr     = w_q_valid ? w_q_head.instr : '0;
   assign if_fault     = w_q_valid && w_q_head.fault;
   assign o_dbg_count  = w_q_count;
   assign o_dbg_halted = r_halted;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          ROM_SIZE = 256;

   logic        HCLK;
   logic        HRESET;
   logic [63:0] HADDR;
   logic [63:0] HWDATA;
   logic [63:0] HRDATA;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;
   logic [2:0]  dbg_count;
   logic        dbg_halted;

   logic [7:0]  rom [ROM_SIZE];
   logic [31:0] golden [6] = '{32'h04000093, 32'h00800113, 32'h00110133,
                               32'h00013183, 32'h00310233, 32'hfe000ce3};
   logic [7:0]  rom_init [24] = '{8'h93, 8'h00, 8'h00, 8'h04, 8'h13, 8'h01, 8'h80, 8'h00,
                                  8'h33, 8'h01, 8'h11, 8'h00, 8'h83, 8'h31, 8'h01, 8'h00,
                                  8'h33, 8'h02, 8'h31, 8'h00, 8'he3, 8'h0c, 8'h00, 8'hfe};

   // Scoreboard: expected delivery stream {pc, instr, fault}
   logic [96:0] exp_q [$];
   logic [63:0] mdl_pc;
   bit          mdl_halt;
   int          gap;
   int          n_asserts;
   int          n_fails;

   ifetch_unit #(
      .RESET_PC  (RESET_PC),
      .ROM_START (64'h0),
      .ROM_SIZE  (ROM_SIZE)
   ) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .HADDR          (HADDR),
      .HWDATA         (HWDATA),
      .HRDATA         (HRDATA),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_fault       (if_fault),
      .o_dbg_count    (dbg_count),
      .o_dbg_halted   (dbg_halted)
   );

   // ---------------- clock ----------------
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Combinational ROM model, little-endian, zero outside the array
   always_comb begin
      HRDATA = '0;
      if (HADDR[63:8] == '0) begin
         for (int b = 0; b < 8; b++) begin
            HRDATA[8*b +: 8] = rom[HADDR[7:0] + 8'(b)];
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: program-order stream from a start PC. An instruction is
   // deliverable if its PC is word aligned and its line lies in the legal
   // window (line start below ROM_SIZE-8); otherwise one fault ends the stream.
   task automatic refill();
      logic [63:0] line;
      logic [31:0] word;
      while (!mdl_halt && exp_q.size() < 4) begin
         line = mdl_pc & ~64'h7;
         if (mdl_pc[1:0] != 2'b00 || line >= 64'(ROM_SIZE - 8)) begin
            exp_q.push_back({mdl_pc, 32'h0, 1'b1});
            mdl_halt = 1'b1;
         end else begin
            word = {rom[mdl_pc[7:0] + 8'd3], rom[mdl_pc[7:0] + 8'd2],
                    rom[mdl_pc[7:0] + 8'd1], rom[mdl_pc[7:0]]};
            exp_q.push_back({mdl_pc, word, 1'b0});
            mdl_pc = mdl_pc + 64'd4;
         end
      end
   endtask

   task automatic model_restart(input logic [63:0] pc);
      exp_q.delete();
      mdl_pc   = pc;
      mdl_halt = 1'b0;
      gap      = 0;
   endtask

   // Called at a negedge with inputs already set: account for the coming
   // rising edge, advance one cycle, then check liveness at the next negedge.
   task automatic cycle();
      logic [96:0] e;
      if (HRESET) begin
         model_restart(RESET_PC);
      end else if (redirect_valid) begin
         model_restart(redirect_pc);
      end else if (if_valid && if_ready) begin
         n_asserts++;
         assert (exp_q.size() != 0) else begin
            n_fails++;
            $error("FAIL sb_unexpected: observed head pc %h, expected no entry", if_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", if_pc, e[96:33]);
            chk("sb_instr", {32'h0, if_instr}, {32'h0, e[32:1]});
            chk("sb_fault", {63'h0, if_fault}, {63'h0, e[0]});
         end
      end
      refill();
      @(posedge HCLK);
      @(negedge HCLK);
      if (if_valid || exp_q.size() == 0) gap = 0;
      else gap++;
      n_asserts++;
      assert (gap <= 2) else begin
         n_fails++;
         $error("FAIL liveness: observed %0d idle cycles with work pending, expected at most 2", gap);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r;
      int sel;
      logic [31:0] w_f0;
      logic [31:0] w_f4;

      n_asserts = 0;
      n_fails   = 0;
      gap       = 0;
      mdl_pc    = RESET_PC;
      mdl_halt  = 1'b0;
      for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'($urandom);
      for (int i = 0; i < 24; i++) rom[i] = rom_init[i];
      w_f0 = {rom[243], rom[242], rom[241], rom[240]};
      w_f4 = {rom[247], rom[246], rom[245], rom[244]};

      HRESET         = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // 1. Reset state, then in-order stream at one instruction per cycle
      cycle();
      cycle();
      chk("rst_valid", {63'h0, if_valid}, 64'h0);
      chk("rst_pc", if_pc, 64'h0);
      chk("rst_instr", {32'h0, if_instr}, 64'h0);
      chk("rst_fault", {63'h0, if_fault}, 64'h0);
      chk("rst_haddr", HADDR, 64'h0);
      chk("rst_hwdata", HWDATA, 64'h0);
      chk("rst_count", {61'h0, dbg_count}, 64'h0);
      HRESET = 1'b0;
      cycle();
      for (int i = 0; i < 6; i++) begin
         chk("stream_valid", {63'h0, if_valid}, 64'h1);
         chk("stream_pc", if_pc, 64'(4 * i));
         chk("stream_instr", {32'h0, if_instr}, {32'h0, golden[i]});
         cycle();
      end

      // 2. Stall: queue fills to 4, HADDR holds, release drains in order
      HRESET   = 1'b1;
      if_ready = 1'b0;
      cycle();
      HRESET = 1'b0;
      repeat (10) cycle();
      chk("stall_count", {61'h0, dbg_count}, 64'h4);
      chk("stall_haddr", HADDR, 64'h10);
      chk("stall_head", if_pc, 64'h0);
      if_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_valid", {63'h0, if_valid}, 64'h1);
         chk("drain_pc", if_pc, 64'(4 * i));
         cycle();
      end

      // 3. Redirect to 0x14 with queued entries
      chk("redir_q_nonempty", {63'h0, if_valid}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h14;
      cycle();
      redirect_valid = 1'b0;
      chk("redir_bubble", {63'h0, if_valid}, 64'h0);
      cycle();
      chk("redir_pc14", if_pc, 64'h14);
      chk("redir_instr14", {32'h0, if_instr}, {32'h0, golden[5]});
      cycle();
      chk("redir_valid18", {63'h0, if_valid}, 64'h1);
      chk("redir_pc18", if_pc, 64'h18);
      cycle();

      // 4. Misaligned redirect produces one fault then freezes
      redirect_valid = 1'b1;
      redirect_pc    = 64'h102;
      cycle();
      redirect_valid = 1'b0;
      chk("mis_bubble", {63'h0, if_valid}, 64'h0);
      cycle();
      chk("mis_pc", if_pc, 64'h102);
      chk("mis_fault", {63'h0, if_fault}, 64'h1);
      chk("mis_instr", {32'h0, if_instr}, 64'h0);
      cycle();
      repeat (3) cycle();
      chk("mis_idle", {63'h0, if_valid}, 64'h0);
      chk("mis_haddr", HADDR, 64'h100);
      chk("mis_halted", {63'h0, dbg_halted}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      chk("resume_pc", if_pc, 64'h0);
      chk("resume_instr", {32'h0, if_instr}, {32'h0, golden[0]});

      // 5. Window edge: line 0xF8 is outside, 0xF0 is inside
      redirect_valid = 1'b1;
      redirect_pc    = 64'hF8;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      chk("edge_f8_pc", if_pc, 64'hF8);
      chk("edge_f8_fault", {63'h0, if_fault}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'hF0;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      chk("edge_f0_pc", if_pc, 64'hF0);
      chk("edge_f0_instr", {32'h0, if_instr}, {32'h0, w_f0});
      chk("edge_f0_fault", {63'h0, if_fault}, 64'h0);
      cycle();
      chk("edge_f4_pc", if_pc, 64'hF4);
      chk("edge_f4_instr", {32'h0, if_instr}, {32'h0, w_f4});
      cycle();
      chk("edge_f8b_pc", if_pc, 64'hF8);
      chk("edge_f8b_fault", {63'h0, if_fault}, 64'h1);
      cycle();

      // 6. Reset while the queue holds three entries
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      if_ready       = 1'b0;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      cycle();
      chk("pre_rst_full", {61'h0, dbg_count}, 64'h4);
      if_ready = 1'b1;
      cycle();
      chk("pre_rst_count3", {61'h0, dbg_count}, 64'h3);
      chk("pre_rst_valid", {63'h0, if_valid}, 64'h1);
      HRESET   = 1'b1;
      if_ready = 1'b0;
      cycle();
      chk("mid_rst_valid", {63'h0, if_valid}, 64'h0);
      chk("mid_rst_count", {61'h0, dbg_count}, 64'h0);
      chk("mid_rst_haddr", HADDR, 64'h0);
      chk("mid_rst_pc", if_pc, 64'h0);
      HRESET   = 1'b0;
      if_ready = 1'b1;
      cycle();
      chk("post_rst_pc", if_pc, 64'h0);
      chk("post_rst_valid", {63'h0, if_valid}, 64'h1);

      // 7. Random backpressure, redirects and resets against the model
      for (int i = 0; i < 3000; i++) begin
         if_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = 1'b0;
         HRESET         = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 3) begin
            redirect_valid = 1'b1;
            sel = $urandom_range(0, 9);
            case (sel)
               0:       redirect_pc = {$urandom, $urandom};
               1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
               2:       redirect_pc = 64'($urandom_range(0, 32'h1FF));
               3:       redirect_pc = 64'($urandom_range(0, 255));
               default: redirect_pc = 64'($urandom_range(0, 63)) << 2;
            endcase
         end else if (r == 3) begin
            HRESET = 1'b1;
         end
         cycle();
      end
      HRESET         = 1'b0;
      redirect_valid = 1'b0;
      if_ready       = 1'b1;
      repeat (8) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM. It owns the fetch PC and drives the ROM's 64-bit address. It splits each 64-bit line returned on HRDATA into 32-bit instructions and buffers them in a 4-entry queue. Decode receives them through a valid/ready handshake, and a redirect port lets the back end steer the fetch PC.

## Interface
- RESET_PC, 64'h0: fetch PC after reset.
- ROM_START, 64'h0: base of the ROM window.
- ROM_SIZE, 256: ROM size in bytes; a line address is legal iff ROM_START <= HADDR < ROM_START+ROM_SIZE-8.
- HCLK  in  1  clock; all state updates on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HADDR  out  64  line address to ROM, always {fetch_pc[63:3],3'b000}.
- HWDATA  out  64  tied to 0.
- HRDATA  in  64  combinational ROM data for HADDR, little-endian; the byte at HADDR is bits [7:0].
- redirect_valid  in  1  load redirect_pc and flush.
- redirect_pc  in  64  new fetch PC.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head.
- if_pc  out  64  PC of head.
- if_instr  out  32  instruction at head; 0 when if_fault.
- if_fault  out  1  head is a fetch fault (misaligned or out of ROM window).

## Operation
- State: fetch_pc (64b), halted flag, queue of 4 entries {pc[63:0], instr[31:0], fault}, count 0..4.
- Fetch condition: !halted && count <= 2 && !redirect_valid. Uses the registered count; a same-cycle pop is ignored.
- On fetch, with legal line and fetch_pc[1:0]==0:
  - fetch_pc[2]==0: push {fetch_pc, HRDATA[31:0]}, then {fetch_pc+4, HRDATA[63:32]}; fetch_pc += 8.
  - fetch_pc[2]==1: push {fetch_pc, HRDATA[63:32]} only; fetch_pc += 4.
- On fetch with fetch_pc[1:0]!=0 or illegal line:
  - Push one entry {fetch_pc, 0, fault=1}.
  - Set halted; HADDR holds.
- Pop when if_valid && if_ready.
  - Push and pop in the same cycle: count += pushes-1.
  - Entries leave in push order.
- Redirect has priority over all other events:
  - Queue is flushed (count=0); any pop that cycle is discarded.
  - fetch_pc=redirect_pc, halted cleared, no push that cycle.
- Reset, including mid-stream:
  - fetch_pc=RESET_PC, count=0, halted=0.
  - if_valid=0, if_pc=0, if_instr=0, if_fault=0; HADDR=aligned RESET_PC; HWDATA=0.
- Arithmetic: PC increments are modulo 2^64. The window check must not overflow; compare HADDR-ROM_START against ROM_SIZE-8 in 64 bits after checking HADDR >= ROM_START.

## Timing
- HADDR derives only from registered fetch_pc; no combinational path from if_ready or redirect_valid to HADDR.
- Fetch latency: an instruction fetched in cycle N appears at the head in cycle N+1 at the earliest (queue is registered).
- After a redirect in cycle N:
  - if_valid=0 in cycle N+1.
  - First new instruction valid in cycle N+2.
- Throughput: sustains 1 instruction/cycle with if_ready held 1.
- Outputs if_* are registered or come from a queue read; if_valid does not depend combinationally on if_ready.
- Full queue (count 3 or 4) with if_ready=0: no fetch; fetch_pc and HADDR hold; no entry is lost or duplicated.

## Structure
- Shared include/package: XLEN=64, ILEN=32, IFQ_DEPTH=4, queue-entry field widths, fault encoding.
- One sub-module, ifetch_queue: a 4-entry FIFO with a 2-wide push port (push_cnt 0..2), a 1-wide pop port, flush, and count output.
- ifetch_unit holds fetch_pc, halted, the window check, and the line splitting.
- Expected size is about 200 lines total.

## Test plan
All scenarios use a ROM with bytes 0..23 = 93 00 00 04 13 01 80 00 33 01 11 00 83 31 01 00 33 02 31 00 e3 0c 00 fe.
- Reset, if_ready=1 -> heads in order:
  - pc 0/0x04000093, 4/0x00800113, 8/0x00110133, 0xC/0x00013183, 0x10/0x00310233, 0x14/0xfe000ce3.
  - One per cycle, first at cycle 2 after reset release.
- if_ready=0 for 10 cycles -> count saturates at 4, HADDR holds 0x10. Release -> pcs 0,4,8,0xC,0x10 follow with no gaps or duplicates.
- Redirect to 0x14 with queue non-empty:
  - Next cycle if_valid=0.
  - Then pc 0x14/0xfe000ce3 (single-half push), then pc 0x18.
  - Queued old entries never appear.
- Redirect to 0x102 -> one fault entry (pc 0x102, if_fault=1, if_instr=0), then if_valid=0 and HADDR frozen. Redirect to 0 -> normal fetch resumes.
- ROM_SIZE=256, redirect to 0xF8 -> fault entry; redirect to 0xF0 -> instructions at 0xF0 and 0xF4 delivered, then a fault at 0xF8.
- HRESET asserted for 1 cycle while queue holds 3 entries and if_valid=1 -> next cycle if_valid=0, count=0, HADDR=0; fetch restarts from pc 0.
